dem_rx_decoder: RTL and testbench



---
 rtl/lib_switchblock_pkg.sv | 16 +
 rtl/dem_usage_monitor.sv | 95 +++++++++
 rtl/dem_rx_decoder.sv | 88 ++++++++
 tb/tb_dem_rx_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// Shared switch-block constants and the DEM usage-monitor state type.
package lib_switchblock_pkg;

  localparam int unsigned MAX_LEVEL    = 7;
  localparam int unsigned OUTPUT_WIDTH = 3;
  localparam int unsigned INPUT_WIDTH  = 16;
  // One quantizer step: the level lands in the top OUTPUT_WIDTH bits of the sample.
  localparam int unsigned QUANT_STEP   = 1 << (INPUT_WIDTH - OUTPUT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ALARM = 2'd2
  } dem_mon_state_t;

endpackage

// File: rtl/dem_usage_monitor.sv
// Per-element usage counters with saturation halving, registered max-min
// spread, and an IDLE/TRACK/ALARM mismatch-shaping alarm FSM.
module dem_usage_monitor
  import lib_switchblock_pkg::*;
#(
  parameter int unsigned NUM_ELEM   = 7,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned SPREAD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_inc,
  input  logic [NUM_ELEM-1:0]  i_elem,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_spread,
  output logic                 o_spread_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] SPREAD_LIM = CNT_WIDTH'(SPREAD_MAX);

  logic [CNT_WIDTH-1:0] r_cnt     [NUM_ELEM];
  logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_ELEM];
  logic                 w_sat;
  logic [CNT_WIDTH-1:0] w_max;
  logic [CNT_WIDTH-1:0] w_min;
  logic [CNT_WIDTH-1:0] r_spread;
  dem_mon_state_t       r_state;
  dem_mon_state_t       w_state_nxt;

  // Halve everything when any counter about to be incremented is already full.
  always_comb begin
    w_sat = 1'b0;
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      if (i_elem[i] && (r_cnt[i] == CNT_MAX)) w_sat = 1'b1;
    end
  end

  // Next counter values: optional halving first, then the increment.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      w_cnt_nxt[i] = (w_sat ? (r_cnt[i] >> 1) : r_cnt[i]) + CNT_WIDTH'(i_elem[i]);
    end
  end

  // Counter state; a clear beats a coincident accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ELEM; i++) r_cnt[i] <= '0;
    end else if (i_clr) begin
      for (int unsigned i = 0; i < NUM_ELEM; i++) r_cnt[i] <= '0;
    end else if (i_inc) begin
      for (int unsigned i = 0; i < NUM_ELEM; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Max/min over the current counter contents.
  always_comb begin
    w_max = r_cnt[0];
    w_min = r_cnt[0];
    for (int unsigned i = 1; i < NUM_ELEM; i++) begin
      if (r_cnt[i] > w_max) w_max = r_cnt[i];
      if (r_cnt[i] < w_min) w_min = r_cnt[i];
    end
  end

  // Spread register, one cycle behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_spread <= '0;
    else if (i_clr) r_spread <= '0;
    else            r_spread <= w_max - w_min;
  end

  // Monitor FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Monitor FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_inc) w_state_nxt = TRACK;
      TRACK:   if (r_spread > SPREAD_LIM) w_state_nxt = ALARM;
      ALARM:   w_state_nxt = ALARM;
      default: w_state_nxt = IDLE;
    endcase
    if (i_clr) w_state_nxt = IDLE;
  end

  assign o_spread     = r_spread;
  assign o_spread_err = (r_state == ALARM);

endmodule

// File: rtl/dem_rx_decoder.sv
// DEM receive decoder: popcount of the element-select vector into a level and
// scaled sample behind a single valid/ready output register.
// Optional usage monitor enabled by macro DEM_USAGE_MON_EN; when undefined,
// spread and spread_err tie to 0 and clr_stats is ignored.
module dem_rx_decoder #(
  parameter int unsigned NUM_ELEM     = lib_switchblock_pkg::MAX_LEVEL,
  parameter int unsigned OUTPUT_WIDTH = lib_switchblock_pkg::OUTPUT_WIDTH,
  parameter int unsigned INPUT_WIDTH  = lib_switchblock_pkg::INPUT_WIDTH,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned SPREAD_MAX   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NUM_ELEM-1:0]     s_elem,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUTPUT_WIDTH-1:0] m_level,
  output logic [INPUT_WIDTH-1:0]  m_sample,
  input  logic                    clr_stats,
  output logic [CNT_WIDTH-1:0]    spread,
  output logic                    spread_err
);

  localparam int unsigned PAD_W = INPUT_WIDTH - OUTPUT_WIDTH;

  logic                    w_s_xfer;
  logic [OUTPUT_WIDTH-1:0] w_level;
  logic [INPUT_WIDTH-1:0]  w_sample;
  logic                    r_m_valid;
  logic [OUTPUT_WIDTH-1:0] r_m_level;
  logic [INPUT_WIDTH-1:0]  r_m_sample;

  assign s_ready  = !r_m_valid || m_ready;
  assign w_s_xfer = s_valid && s_ready;

  // Count active elements to recover the quantizer level.
  always_comb begin
    w_level = '0;
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      w_level = w_level + OUTPUT_WIDTH'(s_elem[i]);
    end
  end

  assign w_sample = {w_level, {PAD_W{1'b0}}};

  // Output register: load on input transfer, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid  <= 1'b0;
      r_m_level  <= '0;
      r_m_sample <= '0;
    end else if (w_s_xfer) begin
      r_m_valid  <= 1'b1;
      r_m_level  <= w_level;
      r_m_sample <= w_sample;
    end else if (m_ready) begin
      r_m_valid  <= 1'b0;
    end
  end

  assign m_valid  = r_m_valid;
  assign m_level  = r_m_level;
  assign m_sample = r_m_sample;

`ifdef DEM_USAGE_MON_EN
  dem_usage_monitor #(
    .NUM_ELEM   (NUM_ELEM),
    .CNT_WIDTH  (CNT_WIDTH),
    .SPREAD_MAX (SPREAD_MAX)
  ) u_usage_monitor (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inc        (w_s_xfer),
    .i_elem       (s_elem),
    .i_clr        (clr_stats),
    .o_spread     (spread),
    .o_spread_err (spread_err)
  );
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_stats;
  assign spread       = '0;
  assign spread_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dem_rx_decoder.sv
// Scoreboard bench for dem_rx_decoder; expectations for spread/spread_err
// follow whether DEM_USAGE_MON_EN is defined for the build.
module tb_dem_rx_decoder;

  localparam int unsigned NE   = 7;
  localparam int unsigned OW   = 3;
  localparam int unsigned IW   = 16;
  localparam int unsigned CW   = 6;
  localparam int unsigned SMAX = 4;
  localparam int          CMAX = (1 << CW) - 1;
`ifdef DEM_USAGE_MON_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [NE-1:0] s_elem;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_level;
  logic [IW-1:0] m_sample;
  logic          clr_stats;
  logic [CW-1:0] spread;
  logic          spread_err;

  dem_rx_decoder #(
    .NUM_ELEM(NE), .OUTPUT_WIDTH(OW), .INPUT_WIDTH(IW),
    .CNT_WIDTH(CW), .SPREAD_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_elem(s_elem), .m_valid(m_valid), .m_ready(m_ready),
    .m_level(m_level), .m_sample(m_sample), .clr_stats(clr_stats),
    .spread(spread), .spread_err(spread_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct { int lvl; int smp; } exp_t;
  exp_t q[$];
  int   n_tx = 0;
  int   n_rx = 0;

  // Reference model state for the cycle about to be entered.
  bit e_mv;
  int e_cnt [NE];
  int e_spread;
  int e_state;   // 0 idle, 1 track, 2 alarm

  // Compare at each falling edge, then advance the model across the next rising edge.
  always @(negedge clk) begin
    bit   xs, xm, sat;
    int   mx, mn, nsp, nst;
    exp_t e;
    if (!rst_n) begin
      n_tx -= q.size();
      q.delete();
      e_mv = 1'b0; e_spread = 0; e_state = 0;
      for (int i = 0; i < NE; i++) e_cnt[i] = 0;
    end else begin
      check_eq("m_valid", m_valid, e_mv);
      check_eq("s_ready", s_ready, !e_mv || m_ready);
      if (e_mv && q.size() > 0) begin
        check_eq("m_level", m_level, q[0].lvl);
        check_eq("m_sample", m_sample, q[0].smp);
      end
      check_eq("spread", spread, MON_EN ? e_spread : 0);
      check_eq("spread_err", spread_err, MON_EN ? (e_state == 2) : 0);

      xm = e_mv && m_ready;
      xs = s_valid && (!e_mv || m_ready);
      if (m_valid && m_ready) n_rx++;

      mx = e_cnt[0]; mn = e_cnt[0];
      for (int i = 1; i < NE; i++) begin
        if (e_cnt[i] > mx) mx = e_cnt[i];
        if (e_cnt[i] < mn) mn = e_cnt[i];
      end
      nsp = clr_stats ? 0 : mx - mn;
      nst = e_state;
      if (clr_stats) nst = 0;
      else if (e_state == 0 && xs) nst = 1;
      else if (e_state == 1 && e_spread > SMAX) nst = 2;
      if (clr_stats) begin
        for (int i = 0; i < NE; i++) e_cnt[i] = 0;
      end else if (xs) begin
        sat = 1'b0;
        for (int i = 0; i < NE; i++) if (s_elem[i] && e_cnt[i] == CMAX) sat = 1'b1;
        for (int i = 0; i < NE; i++) e_cnt[i] = (sat ? e_cnt[i] / 2 : e_cnt[i]) + int'(s_elem[i]);
      end
      e_spread = nsp;
      e_state  = nst;

      if (xm) void'(q.pop_front());
      if (xs) begin
        e.lvl = $countones(s_elem);
        e.smp = e.lvl * 8192;
        q.push_back(e);
        n_tx++;
      end
      e_mv = xs ? 1'b1 : (xm ? 1'b0 : e_mv);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_elem = '0; clr_stats = 1'b0; m_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_m_level", m_level, 0);
    check_eq("rst_m_sample", m_sample, 0);
    check_eq("rst_spread", spread, 0);
    check_eq("rst_spread_err", spread_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present a word and hold it until it has been accepted (bounded).
  task automatic send(input logic [NE-1:0] v);
    bit ok;
    int guard;
    ok = 1'b0; guard = 0;
    s_valid = 1'b1; s_elem = v;
    while (!ok && guard < 100) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      guard++;
    end
    check_eq("send_accepted", ok, 1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Back-to-back zero and full-scale words, one-cycle latency each.
    send(7'b0000000);
    check_eq("lat_level0", m_level, 0);
    check_eq("lat_sample0", m_sample, 16'h0000);
    send(7'b1111111);
    check_eq("lat_level7", m_level, 7);
    check_eq("lat_sample7", m_sample, 16'hE000);
    idle(2);

    // Downstream stall: held output, ready low, nothing lost after release.
    m_ready = 1'b0;
    send(7'b0000011);
    s_valid = 1'b1; s_elem = 7'b0011111;
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_s_ready", s_ready, 0);
      check_eq("stall_level", m_level, 2);
      check_eq("stall_sample", m_sample, 16'h4000);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    send(7'b0011111);
    idle(3);
    check_eq("stall_drained", q.size(), 0);
    check_eq("stall_rx_count", n_rx, n_tx);

    // Five hits on element 0 trip the alarm; clear restores idle.
    do_reset();
    repeat (5) send(7'b0000001);
    idle(3);
    check_eq("alarm_spread", spread, MON_EN ? 5 : 0);
    check_eq("alarm_err", spread_err, MON_EN ? 1 : 0);
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    idle(2);
    check_eq("clr_spread", spread, 0);
    check_eq("clr_err", spread_err, 0);

    // Clear coincident with accepted words: word not counted, still decoded.
    repeat (3) send(7'b0000001);
    clr_stats = 1'b1; send(7'b1111111); clr_stats = 1'b0;
    check_eq("clrx_level", m_level, 7);
    idle(2);
    check_eq("clrx_spread", spread, 0);
    clr_stats = 1'b1; send(7'b0000001); clr_stats = 1'b0;
    idle(2);
    check_eq("clrx1_spread", spread, 0);

    // Rotating single-hot over 700 words, crossing counter saturation.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      send(NE'(1 << (i % NE)));
      if (i % 50 == 49) check_eq("rot_spread_le1", spread <= 1, 1);
    end
    idle(2);
    check_eq("rot_err", spread_err, 0);

    // Single element driven past saturation.
    repeat (70) send(7'b0000001);
    idle(2);

    // Mixed random traffic with random backpressure.
    for (int i = 0; i < 200; i++) begin
      m_ready   = 1'($urandom_range(0, 1));
      s_valid   = 1'($urandom_range(0, 1));
      s_elem    = NE'($urandom);
      clr_stats = ($urandom_range(0, 31) == 0);
      tick();
    end
    clr_stats = 1'b0; m_ready = 1'b1;
    idle(3);
    check_eq("rand_rx_count", n_rx, n_tx);

    // Reset in the middle of a stall discards the held result.
    m_ready = 1'b0;
    send(7'b1010101);
    idle(2);
    do_reset();
    idle(3);
    check_eq("post_rst_m_valid", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
